// File: rtl/signal_cfg_packer_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : signal_cfg_packer_if
// Description : Write, commit, publish and readback signals of the
//               configuration packer. The master modport is the
//               configuration host. The slave modport is the packer.
// Revision    : 1.0 - initial release
// ============================================================================
interface signal_cfg_packer_if;
    // Host write channel into the shadow bank
    logic         wr_valid;
    logic         wr_ready;
    logic [4:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         wr_err;

    // Commit control
    logic         commit_req;
    logic         sync_en;
    logic         period_tick;
    logic         commit_busy;

    // Published configuration word
    logic [831:0] cfg_data;
    logic         cfg_update;

    // Shadow readback
    logic [4:0]   rd_addr;
    logic [31:0]  rd_data;

    modport master (
        output wr_valid, wr_addr, wr_data, commit_req, sync_en, period_tick, rd_addr,
        input  wr_ready, wr_err, commit_busy, cfg_data, cfg_update, rd_data
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, commit_req, sync_en, period_tick, rd_addr,
        output wr_ready, wr_err, commit_busy, cfg_data, cfg_update, rd_data
    );
endinterface
`default_nettype wire

// File: rtl/signal_cfg_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : signal_cfg_packer
// Description : Double-buffered 26 x 32-bit configuration packer.
//               Host writes go into a shadow bank. A commit copies the
//               whole bank into the 832-bit active word in one edge. The
//               copy happens at once, or it waits for a period_tick.
//               A period_tick wait can be cut short by an optional timeout.
//               Optional feature macro: SIGNAL_CFG_PACKER_READBACK_EN.
//               When it is defined, rd_data returns the addressed shadow
//               word one cycle later. When it is not defined, rd_data is
//               tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module signal_cfg_packer #(
    parameter int TICK_TIMEOUT = 0          // max PENDING cycles, 0 = wait forever
) (
    input  wire logic          aclk,
    input  wire logic          aresetn,
    signal_cfg_packer_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int              N_WORDS   = 26;
    localparam logic [4:0]      LAST_WORD = 5'd25;

    // Words whose upper half is reserved: 5, 7, 11, 13, 17, 19, 23, 25
    localparam logic [N_WORDS-1:0] RSV_HI_MASK = 26'h28A_28A0;

    // Counter wide enough to hold TICK_TIMEOUT (at least one bit)
    localparam int              CNT_W       = (TICK_TIMEOUT < 2) ? 1 : $clog2(TICK_TIMEOUT + 1);
    localparam logic [CNT_W:0]  TIMEOUT_VAL = (CNT_W + 1)'(TICK_TIMEOUT);
    localparam bit              TIMEOUT_ON  = (TICK_TIMEOUT != 0);

    // ------------------------------------------------------------------------
    // Commit state machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_APPLY   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             state_d;

    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W:0]     w_cnt_inc;

    logic               wr_ready_q;
    logic               wr_err_q;
    logic               cfg_update_q;

    logic               w_wr_fire;
    logic               w_addr_ok;
    logic               w_timeout;
    logic [31:0]        w_keep;

    logic [31:0]        shadow_q [N_WORDS];
    logic [31:0]        cfg_q    [N_WORDS];
    logic [831:0]       w_cfg_flat;

    // ------------------------------------------------------------------------
    // Write decode
    // ------------------------------------------------------------------------
    // wr_ready is only high in IDLE, so the bank cannot change once a
    // commit has started. A write in the commit_req cycle still lands
    // before the copy.
    assign w_wr_fire = bus.wr_valid && wr_ready_q;
    assign w_addr_ok = (bus.wr_addr <= LAST_WORD);

    // Reserved upper halves are stripped as data enters the bank. The
    // active copy therefore never carries those bits.
    assign w_keep    = (w_addr_ok && RSV_HI_MASK[bus.wr_addr]) ? 32'h0000_FFFF : 32'hFFFF_FFFF;

    // ------------------------------------------------------------------------
    // Timeout compare
    // ------------------------------------------------------------------------
    // The compare uses the count that includes the current PENDING cycle.
    // Apply is then forced after exactly TICK_TIMEOUT PENDING cycles.
    assign w_cnt_inc = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign w_timeout = TIMEOUT_ON && (w_cnt_inc >= TIMEOUT_VAL);

    // Next-state and timeout-counter logic for the commit FSM
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: begin
                // commit_req is only acted on here; elsewhere it is dropped
                if (bus.commit_req) begin
                    state_d = bus.sync_en ? ST_PENDING : ST_APPLY;
                end
            end
            ST_PENDING: begin
                cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                if (bus.period_tick || !bus.sync_en || w_timeout) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM state and timeout counter registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered handshake and strobe outputs
    // wr_ready follows the next state so it stays low during reset.
    // It rises on the first edge after reset is released.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ready_q   <= 1'b0;
            wr_err_q     <= 1'b0;
            cfg_update_q <= 1'b0;
        end else begin
            wr_ready_q   <= (state_d == ST_IDLE);
            wr_err_q     <= w_wr_fire && !w_addr_ok;
            cfg_update_q <= (state_q == ST_APPLY);
        end
    end

    // Shadow bank: host writes to words 0..25, other addresses are dropped
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < N_WORDS; k++) begin
                shadow_q[k] <= '0;
            end
        end else if (w_wr_fire && w_addr_ok) begin
            shadow_q[bus.wr_addr] <= bus.wr_data & w_keep;
        end
    end

    // Active bank: the whole shadow is copied in the single APPLY cycle
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int k = 0; k < N_WORDS; k++) begin
                cfg_q[k] <= '0;
            end
        end else if (state_q == ST_APPLY) begin
            for (int k = 0; k < N_WORDS; k++) begin
                cfg_q[k] <= shadow_q[k];
            end
        end
    end

    // Flatten the active bank; word k occupies bits [32k+31:32k]
    always_comb begin
        w_cfg_flat = '0;
        for (int k = 0; k < N_WORDS; k++) begin
            w_cfg_flat[32*k +: 32] = cfg_q[k];
        end
    end

    // ------------------------------------------------------------------------
    // Readback
    // ------------------------------------------------------------------------
`ifdef SIGNAL_CFG_PACKER_READBACK_EN
    logic [31:0] rd_data_q;

    // One-cycle registered readback of the shadow bank; holes read as zero
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_data_q <= '0;
        end else if (bus.rd_addr <= LAST_WORD) begin
            rd_data_q <= shadow_q[bus.rd_addr];
        end else begin
            rd_data_q <= '0;
        end
    end

    assign bus.rd_data = rd_data_q;
`else
    // The port is kept for pin compatibility. No read mux is built.
    logic w_unused_rd_addr;
    assign w_unused_rd_addr = ^bus.rd_addr;
    assign bus.rd_data      = '0;
`endif

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.wr_ready    = wr_ready_q;
    assign bus.wr_err      = wr_err_q;
    assign bus.commit_busy = (state_q != ST_IDLE);
    assign bus.cfg_data    = w_cfg_flat;
    assign bus.cfg_update  = cfg_update_q;

endmodule
`default_nettype wire

// File: tb/tb_signal_cfg_packer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_signal_cfg_packer
// Description : Directed testbench for signal_cfg_packer. dut_a uses the
//               default TICK_TIMEOUT of 0. dut_b uses TICK_TIMEOUT=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_signal_cfg_packer;

    logic aclk;
    logic aresetn;
    int   n_vec;
    int   n_miss;

    signal_cfg_packer_if bus_a();
    signal_cfg_packer_if bus_b();

    signal_cfg_packer #(.TICK_TIMEOUT(0)) u_dut_a (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus_a.slave)
    );

    signal_cfg_packer #(.TICK_TIMEOUT(4)) u_dut_b (
        .aclk    (aclk),
        .aresetn (aresetn),
        .bus     (bus_b.slave)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Single comparison point
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic write_a(input logic [4:0] a, input logic [31:0] d);
        bus_a.wr_valid = 1'b1;
        bus_a.wr_addr  = a;
        bus_a.wr_data  = d;
        step();
        bus_a.wr_valid = 1'b0;
    endtask

    task automatic commit_a(input logic se);
        bus_a.commit_req = 1'b1;
        bus_a.sync_en    = se;
        step();
        bus_a.commit_req = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;
        aresetn = 1'b0;
        bus_a.wr_valid = 0; bus_a.wr_addr = 0; bus_a.wr_data = 0; bus_a.commit_req = 0;
        bus_a.sync_en  = 0; bus_a.period_tick = 0; bus_a.rd_addr = 0;
        bus_b.wr_valid = 0; bus_b.wr_addr = 0; bus_b.wr_data = 0; bus_b.commit_req = 0;
        bus_b.sync_en  = 0; bus_b.period_tick = 0; bus_b.rd_addr = 0;

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_wr_ready",    bus_a.wr_ready,        64'd0);
        chk("rst_busy",        bus_a.commit_busy,     64'd0);
        chk("rst_cfg_update",  bus_a.cfg_update,      64'd0);
        chk("rst_wr_err",      bus_a.wr_err,          64'd0);
        chk("rst_cfg_lo",      bus_a.cfg_data[63:0],  64'd0);
        chk("rst_rd_data",     bus_a.rd_data,         64'd0);
        aresetn = 1'b1;
        step();
        chk("rel_wr_ready",    bus_a.wr_ready,        64'd1);

        // ---------------- immediate commit, write in commit cycle ----------------
        write_a(5'd0, 32'h1234_5678);
        bus_a.wr_valid   = 1'b1;
        bus_a.wr_addr    = 5'd1;
        bus_a.wr_data    = 32'hABCD_0001;
        bus_a.commit_req = 1'b1;
        bus_a.sync_en    = 1'b0;
        step();
        bus_a.wr_valid   = 1'b0;
        bus_a.commit_req = 1'b0;
        chk("c1_busy",         bus_a.commit_busy,     64'd1);
        chk("c1_wr_ready",     bus_a.wr_ready,        64'd0);
        chk("c1_upd_early",    bus_a.cfg_update,      64'd0);
        chk("c1_cfg_early",    bus_a.cfg_data[63:0],  64'd0);
        step();
        chk("c1_cfg_lo",       bus_a.cfg_data[63:0],  64'hABCD_0001_1234_5678);
        chk("c1_upd",          bus_a.cfg_update,      64'd1);
        chk("c1_idle",         bus_a.commit_busy,     64'd0);
        step();
        chk("c1_upd_single",   bus_a.cfg_update,      64'd0);
        chk("c1_cfg_hold",     bus_a.cfg_data[63:0],  64'hABCD_0001_1234_5678);

        // ---------------- reserved-bit masking ----------------
        write_a(5'd5,  32'hFFFF_FFFF);
        write_a(5'd4,  32'hFFFF_FFFF);
        write_a(5'd25, 32'hCAFE_BABE);
        chk("w25_no_err",      bus_a.wr_err,          64'd0);
        commit_a(1'b0);
        step();
        chk("rsv_word5",       bus_a.cfg_data[191:160], 64'h0000_FFFF);
        chk("full_word4",      bus_a.cfg_data[159:128], 64'hFFFF_FFFF);
        chk("rsv_word25",      bus_a.cfg_data[831:800], 64'h0000_BABE);

        // ---------------- synchronised commit, tick after 10 cycles ----------------
        write_a(5'd2, 32'h55AA_55AA);
        commit_a(1'b1);
        bus_a.wr_valid = 1'b1;
        bus_a.wr_addr  = 5'd2;
        bus_a.wr_data  = 32'h1111_1111;
        for (int i = 0; i < 10; i++) begin
            chk("pend_wr_ready", bus_a.wr_ready,    64'd0);
            chk("pend_busy",     bus_a.commit_busy, 64'd1);
            chk("pend_no_upd",   bus_a.cfg_update,  64'd0);
            bus_a.commit_req = (i == 4);
            step();
        end
        bus_a.period_tick = 1'b1;
        step();
        bus_a.period_tick = 1'b0;
        bus_a.wr_valid    = 1'b0;
        bus_a.sync_en     = 1'b0;
        chk("tick_word2_old",  bus_a.cfg_data[95:64], 64'd0);
        chk("tick_upd_early",  bus_a.cfg_update,      64'd0);
        step();
        chk("tick_word2_new",  bus_a.cfg_data[95:64], 64'h55AA_55AA);
        chk("tick_upd",        bus_a.cfg_update,      64'd1);
        step();
        chk("no_queued_commit", bus_a.commit_busy,    64'd0);
        chk("tick_upd_single", bus_a.cfg_update,      64'd0);

        // ---------------- out-of-range writes ----------------
        write_a(5'd30, 32'h7777_7777);
        chk("err30_pulse",     bus_a.wr_err,          64'd1);
        step();
        chk("err30_clear",     bus_a.wr_err,          64'd0);
        write_a(5'd26, 32'h8888_8888);
        chk("err26_pulse",     bus_a.wr_err,          64'd1);
        commit_a(1'b0);
        step();
        chk("err_upd",         bus_a.cfg_update,      64'd1);
        chk("err_cfg_lo",      bus_a.cfg_data[63:0],  64'hABCD_0001_1234_5678);
        chk("err_word2",       bus_a.cfg_data[95:64], 64'h55AA_55AA);
        chk("err_word25",      bus_a.cfg_data[831:800], 64'h0000_BABE);

        // ---------------- readback ----------------
        write_a(5'd3, 32'hDEAD_BEEF);
        bus_a.rd_addr = 5'd3;
        step();
`ifdef SIGNAL_CFG_PACKER_READBACK_EN
        chk("rd_word3",        bus_a.rd_data,         64'hDEAD_BEEF);
`else
        chk("rd_word3_off",    bus_a.rd_data,         64'd0);
`endif
        bus_a.rd_addr = 5'd30;
        step();
        chk("rd_hole",         bus_a.rd_data,         64'd0);
        bus_a.rd_addr = 5'd0;
        step();
`ifdef SIGNAL_CFG_PACKER_READBACK_EN
        chk("rd_word0",        bus_a.rd_data,         64'h1234_5678);
`else
        chk("rd_word0_off",    bus_a.rd_data,         64'd0);
`endif

        // ---------------- forced apply after TICK_TIMEOUT=4 ----------------
        bus_b.wr_valid = 1'b1;
        bus_b.wr_addr  = 5'd0;
        bus_b.wr_data  = 32'h0BAD_F00D;
        step();
        bus_b.wr_valid   = 1'b0;
        bus_b.commit_req = 1'b1;
        bus_b.sync_en    = 1'b1;
        step();
        bus_b.commit_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_busy",     bus_b.commit_busy,     64'd1);
            chk("to_no_upd",   bus_b.cfg_update,      64'd0);
            chk("to_cfg_old",  bus_b.cfg_data[31:0],  64'd0);
            step();
        end
        chk("to_apply_busy",   bus_b.commit_busy,     64'd1);
        chk("to_apply_old",    bus_b.cfg_data[31:0],  64'd0);
        step();
        chk("to_cfg_new",      bus_b.cfg_data[31:0],  64'h0BAD_F00D);
        chk("to_upd",          bus_b.cfg_update,      64'd1);
        bus_b.sync_en = 1'b0;

        // ---------------- reset during PENDING ----------------
        write_a(5'd6, 32'h1357_2468);
        commit_a(1'b1);
        step();
        step();
        chk("rp_busy_before",  bus_a.commit_busy,     64'd1);
        aresetn = 1'b0;
        #1;
        chk("rp_cfg_lo",       bus_a.cfg_data[63:0],  64'd0);
        chk("rp_cfg_w2",       bus_a.cfg_data[95:64], 64'd0);
        chk("rp_busy",         bus_a.commit_busy,     64'd0);
        chk("rp_wr_ready",     bus_a.wr_ready,        64'd0);
        chk("rp_upd",          bus_a.cfg_update,      64'd0);
        bus_a.sync_en = 1'b0;
        step();
        chk("rp_upd_held",     bus_a.cfg_update,      64'd0);
        aresetn = 1'b1;
        step();
        chk("rp_rel_wr_ready", bus_a.wr_ready,        64'd1);
        chk("rp_rel_busy",     bus_a.commit_busy,     64'd0);
        chk("rp_rel_upd",      bus_a.cfg_update,      64'd0);
        commit_a(1'b0);
        step();
        chk("rp_post_upd",     bus_a.cfg_update,      64'd1);
        chk("rp_post_word6",   bus_a.cfg_data[223:192], 64'd0);
        chk("rp_post_cfg_lo",  bus_a.cfg_data[63:0],  64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/signal_cfg_packer.md
SIGNAL_CFG_PACKER -- requirements
Module: signal_cfg_packer

Interface
REQ-001 SHALL have parameter TICK_TIMEOUT, default 0, giving the maximum PENDING cycles before a forced apply; 0 disables the timeout.
REQ-002 SHALL have port aclk  input  1  sole clock; all logic is rising-edge.
REQ-003 SHALL have port aresetn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port wr_valid  input  1  write request.
REQ-005 SHALL have port wr_ready  output  1  write accepted when wr_valid&&wr_ready.
REQ-006 SHALL have port wr_addr  input  5  32-bit word index into the configuration word.
REQ-007 SHALL have port wr_data  input  32  write data.
REQ-008 SHALL have port wr_err  output  1  one-cycle pulse on an accepted write with wr_addr>25.
REQ-009 SHALL have port commit_req  input  1  request to publish the shadow bank.
REQ-010 SHALL have port sync_en  input  1  1 = wait for period_tick before publishing.
REQ-011 SHALL have port period_tick  input  1  waveform period boundary strobe.
REQ-012 SHALL have port commit_busy  output  1  high while state is not IDLE.
REQ-013 SHALL have port cfg_data  output  832  active configuration word, consumed by the signal configuration slicer.
REQ-014 SHALL have port cfg_update  output  1  one-cycle pulse on the edge where cfg_data changes.
REQ-015 SHALL have port rd_addr  input  5  readback word index.
REQ-016 SHALL have port rd_data  output  32  readback data.

Function
REQ-017 SHALL hold a 26x32-bit shadow bank; word k maps to cfg_data[32k+31:32k].
REQ-018 SHALL write wr_data to shadow word wr_addr on each accepted write with wr_addr<=25.
REQ-019 SHALL ignore the data of an accepted write with wr_addr 26..31 and pulse wr_err on the next edge.
REQ-020 SHALL force reserved bits [31:16] of shadow words 5, 7, 11, 13, 17, 19, 23 and 25 to zero on write; cfg_data bits 176-191, 240-255, 368-383, 432-447, 560-575, 624-639, 752-767 and 816-831 are always 0.
REQ-021 SHALL implement FSM IDLE/PENDING/APPLY; IDLE+commit_req: sync_en=0 -> APPLY, sync_en=1 -> PENDING.
REQ-022 SHALL go PENDING->APPLY when period_tick=1, when sync_en=0, or when the timeout counter reaches TICK_TIMEOUT (if TICK_TIMEOUT!=0).
REQ-023 SHALL, in APPLY, copy the full shadow bank to cfg_data and pulse cfg_update on the same edge, then return to IDLE.
REQ-024 SHALL give a commit latency of 2 edges from a sampled commit_req to a cfg_data change when sync_en=0, and 1 edge after the sampled period_tick when in PENDING.
REQ-025 SHALL drive wr_ready=1 only in IDLE; writes stall in PENDING/APPLY so a published word is atomic.
REQ-026 SHALL include in the commit a write accepted in the same cycle as the commit_req.
REQ-027 SHALL ignore commit_req outside IDLE (no queueing).
REQ-028 SHALL clear the timeout counter on entry to PENDING and count one per PENDING cycle, saturating.
REQ-029 SHALL hold cfg_data stable between cfg_update pulses.

Reset
REQ-030 SHALL, with aresetn low, asynchronously clear the shadow bank, cfg_data, cfg_update, wr_err, rd_data and the counter, force state=IDLE and commit_busy=0, and drive wr_ready=0.
REQ-031 SHALL abandon a reset asserted mid-PENDING/APPLY with no cfg_update pulse; wr_ready=1 on the first edge after release.

Configuration
REQ-032 SHALL, with SIGNAL_CFG_PACKER_READBACK_EN defined, register rd_data = shadow[rd_addr] with 1-cycle latency, and 0 for rd_addr>25.
REQ-033 SHALL, without SIGNAL_CFG_PACKER_READBACK_EN, keep the rd_addr/rd_data ports with rd_data constant 0 and infer no read mux.

Verification
REQ-034 SHALL verify: write word0=0x12345678 and word1=0xABCD0001, commit with sync_en=0 -> cfg_data[63:0]=0xABCD000112345678 two edges later, single cfg_update pulse.
REQ-035 SHALL verify: write word5=0xFFFFFFFF, commit -> cfg_data[191:160]=0x0000FFFF.
REQ-036 SHALL verify: sync_en=1, commit, period_tick after 10 cycles -> wr_ready=0 for those cycles, cfg_data changes 1 edge after the tick.
REQ-037 SHALL verify: TICK_TIMEOUT=4, sync_en=1, no tick -> apply forced after 4 PENDING cycles.
REQ-038 SHALL verify: write to addr 30 -> wr_err pulse, all words unchanged; readback (macro on) of word3 after writing 0xDEADBEEF -> 0xDEADBEEF one cycle later.
REQ-039 SHALL verify: aresetn low during PENDING -> cfg_data=0, no cfg_update, state IDLE.
